// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN execution sequencer:
// operator codes, error codes and the sequencer state type.
package rpn_pkg;

    localparam logic [3:0] OP_ADD     = 4'd0;
    localparam logic [3:0] OP_SUB     = 4'd1;
    localparam logic [3:0] OP_MUL     = 4'd2;
    localparam logic [3:0] OP_DIV     = 4'd3;
    localparam logic [3:0] OP_POP     = 4'd4;
    localparam logic [3:0] OP_UNKNOWN = 4'hf;

    localparam logic [1:0] ERR_UNDER = 2'd0;
    localparam logic [1:0] ERR_OVER  = 2'd1;
    localparam logic [1:0] ERR_UNK   = 2'd2;
    localparam logic [1:0] ERR_DIV0  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        PRINT,
        ERR
    } state_e;

endpackage

// File: rtl/rpn_exec_sequencer_stack.sv
// Operand stack: register array with push, pop1/pop2,
// peek of top and top-1, and the occupancy counter.
module rpn_stack
    import rpn_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop1_i,
    input  logic              pop2_i,
    output logic [DATA_W-1:0] top_o,
    output logic [DATA_W-1:0] next_o,
    output logic [CNT_W-1:0]  depth_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              has2_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]  depth_q;
    logic [CNT_W-1:0]  depth_d;

    always_comb begin
        depth_d = depth_q;
        unique case (1'b1)
            push_i:  depth_d = depth_q + CNT_W'(1);
            pop1_i:  depth_d = depth_q - CNT_W'(1);
            pop2_i:  depth_d = depth_q - CNT_W'(2);
            default: depth_d = depth_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    // Contents are don't-care after reset, so the array has no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push_i && depth_q == CNT_W'(i)) begin
                mem_q[i] <= push_data_i;
            end
        end
    end

    always_comb begin
        top_o  = '0;
        next_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (depth_q == CNT_W'(i + 1)) top_o = mem_q[i];
            if (depth_q == CNT_W'(i + 2)) next_o = mem_q[i];
        end
    end

    assign depth_o = depth_q;
    assign full_o  = (depth_q == CNT_W'(DEPTH));
    assign empty_o = (depth_q == '0);
    assign has2_o  = (depth_q >= CNT_W'(2));

endmodule

// File: rtl/rpn_exec_sequencer.sv
// RPN token sequencer: pushes numbers, dispatches operators
// to the external ALU and pops values to the print formatter.
module rpn_exec_sequencer
    import rpn_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tok_valid,
    output logic              tok_ready,
    input  logic              tok_is_op,
    input  logic [3:0]        tok_op,
    input  logic [DATA_W-1:0] tok_val,
    output logic              alu_start,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic              alu_done,
    input  logic              alu_err,
    input  logic [DATA_W-1:0] alu_result,
    output logic              print_valid,
    output logic [DATA_W-1:0] print_data,
    input  logic              print_ready,
    output logic              err_valid,
    output logic [1:0]        err_code,
    output logic [CNT_W-1:0]  depth,
    output logic              busy
);

    state_e            state_q;
    logic              alu_start_q;
    logic [3:0]        alu_op_q;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic              print_valid_q;
    logic [DATA_W-1:0] print_data_q;
    logic              err_valid_q;
    logic [1:0]        err_code_q;

    logic [DATA_W-1:0] top;
    logic [DATA_W-1:0] nxt;
    logic              full;
    logic              empty;
    logic              has2;

    logic accept;
    logic is_arith;
    logic is_pop;
    logic alu_ok;
    logic push;
    logic pop1;
    logic pop2;

    assign accept   = tok_valid && (state_q == IDLE);
    assign is_arith = tok_op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV};
    assign is_pop   = (tok_op == OP_POP);
    assign alu_ok   = (state_q == EXEC) && alu_done && !alu_err;

    // Stack updates happen in the same cycle the token is accepted.
    assign push = (accept && !tok_is_op && !full) || alu_ok;
    assign pop2 = accept && tok_is_op && is_arith && has2;
    assign pop1 = accept && tok_is_op && is_pop && !empty;

    rpn_stack #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_stack (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (alu_ok ? alu_result : tok_val),
        .pop1_i      (pop1),
        .pop2_i      (pop2),
        .top_o       (top),
        .next_o      (nxt),
        .depth_o     (depth),
        .full_o      (full),
        .empty_o     (empty),
        .has2_o      (has2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            alu_start_q   <= 1'b0;
            alu_op_q      <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            print_valid_q <= 1'b0;
            print_data_q  <= '0;
            err_valid_q   <= 1'b0;
            err_code_q    <= '0;
        end else begin
            alu_start_q <= 1'b0;
            err_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept && !tok_is_op) begin
                        if (full) begin
                            state_q     <= ERR;
                            err_valid_q <= 1'b1;
                            err_code_q  <= ERR_OVER;
                        end
                    end else if (accept) begin
                        unique case (1'b1)
                            is_arith: begin
                                if (!has2) begin
                                    state_q     <= ERR;
                                    err_valid_q <= 1'b1;
                                    err_code_q  <= ERR_UNDER;
                                end else begin
                                    state_q     <= EXEC;
                                    alu_start_q <= 1'b1;
                                    alu_op_q    <= tok_op;
                                    alu_a_q     <= nxt;
                                    alu_b_q     <= top;
                                end
                            end
                            is_pop: begin
                                if (empty) begin
                                    state_q     <= ERR;
                                    err_valid_q <= 1'b1;
                                    err_code_q  <= ERR_UNDER;
                                end else begin
                                    state_q       <= PRINT;
                                    print_valid_q <= 1'b1;
                                    print_data_q  <= top;
                                end
                            end
                            default: begin
                                state_q     <= ERR;
                                err_valid_q <= 1'b1;
                                err_code_q  <= ERR_UNK;
                            end
                        endcase
                    end
                end
                EXEC: begin
                    if (alu_done && alu_err) begin
                        state_q     <= ERR;
                        err_valid_q <= 1'b1;
                        err_code_q  <= ERR_DIV0;
                    end else if (alu_done) begin
                        state_q <= IDLE;
                    end
                end
                PRINT: begin
                    if (print_ready) begin
                        state_q       <= IDLE;
                        print_valid_q <= 1'b0;
                    end
                end
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tok_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign alu_start   = alu_start_q;
    assign alu_op      = alu_op_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign print_valid = print_valid_q;
    assign print_data  = print_data_q;
    assign err_valid   = err_valid_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_rpn_exec_sequencer.sv
// Directed bench for rpn_exec_sequencer with scoreboard queues
// for ALU requests, print transfers and error pulses.
module tb_rpn_exec_sequencer;
    import rpn_pkg::*;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic              tok_valid;
    logic              tok_ready;
    logic              tok_is_op;
    logic [3:0]        tok_op;
    logic [DATA_W-1:0] tok_val;
    logic              alu_start;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              alu_done;
    logic              alu_err;
    logic [DATA_W-1:0] alu_result;
    logic              print_valid;
    logic [DATA_W-1:0] print_data;
    logic              print_ready;
    logic              err_valid;
    logic [1:0]        err_code;
    logic [CNT_W-1:0]  depth;
    logic              busy;

    int n_chk  = 0;
    int n_fail = 0;

    logic [35:0]       exp_alu [$];
    logic [DATA_W-1:0] exp_prt [$];
    logic [1:0]        exp_err [$];

    rpn_exec_sequencer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tok_valid   (tok_valid),
        .tok_ready   (tok_ready),
        .tok_is_op   (tok_is_op),
        .tok_op      (tok_op),
        .tok_val     (tok_val),
        .alu_start   (alu_start),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_done    (alu_done),
        .alu_err     (alu_err),
        .alu_result  (alu_result),
        .print_valid (print_valid),
        .print_data  (print_data),
        .print_ready (print_ready),
        .err_valid   (err_valid),
        .err_code    (err_code),
        .depth       (depth),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [35:0] obs,
                       input logic [35:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] v);
        tok_valid = 1'b1;
        tok_is_op = 1'b0;
        tok_val   = v;
        tick();
        tok_valid = 1'b0;
    endtask

    task automatic op(input logic [3:0] c);
        tok_valid = 1'b1;
        tok_is_op = 1'b1;
        tok_op    = c;
        tick();
        tok_valid = 1'b0;
        tok_is_op = 1'b0;
    endtask

    task automatic pop_now(input logic [DATA_W-1:0] v);
        exp_prt.push_back(v);
        op(OP_POP);
        print_ready = 1'b1;
        tick();
        print_ready = 1'b0;
    endtask

    task automatic err_pulse(input logic [1:0] code,
                             input logic [CNT_W-1:0] d);
        chk("err_valid", 36'(err_valid), 36'd1);
        chk("err_code", 36'(err_code), 36'(code));
        chk("err_depth", 36'(depth), 36'(d));
        tick();
        chk("err_drop", 36'(err_valid), 36'd0);
        chk("err_idle", 36'(tok_ready), 36'd1);
    endtask

    // Output monitor: every DUT event must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (alu_start) begin
                n_chk++;
                assert (exp_alu.size() > 0) else begin
                    n_fail++;
                    $error("FAIL alu_unexpected: observed start expected none");
                end
                if (exp_alu.size() > 0)
                    chk("alu_req", {alu_op, alu_a, alu_b}, exp_alu.pop_front());
            end
            if (err_valid) begin
                n_chk++;
                assert (exp_err.size() > 0) else begin
                    n_fail++;
                    $error("FAIL err_unexpected: observed code %0d expected none",
                           err_code);
                end
                if (exp_err.size() > 0)
                    chk("err_seq", 36'(err_code), 36'(exp_err.pop_front()));
            end
            if (print_valid && print_ready) begin
                n_chk++;
                assert (exp_prt.size() > 0) else begin
                    n_fail++;
                    $error("FAIL print_unexpected: observed %0h expected none",
                           print_data);
                end
                if (exp_prt.size() > 0)
                    chk("print_seq", 36'(print_data), 36'(exp_prt.pop_front()));
            end
        end
    end

    initial begin
        rst         = 1'b1;
        tok_valid   = 1'b0;
        tok_is_op   = 1'b0;
        tok_op      = '0;
        tok_val     = '0;
        alu_done    = 1'b0;
        alu_err     = 1'b0;
        alu_result  = '0;
        print_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 36'(tok_ready), 36'd1);
        chk("rst_depth", 36'(depth), 36'd0);
        chk("rst_busy", 36'(busy), 36'd0);
        chk("rst_outs", {33'(alu_start), print_valid, err_valid, 1'b0},
            36'd0);
        rst = 1'b0;

        // 3 4 ADD with a two-cycle ALU
        push(16'd3);
        chk("push1_depth", 36'(depth), 36'd1);
        push(16'd4);
        chk("push2_depth", 36'(depth), 36'd2);
        exp_alu.push_back({OP_ADD, 16'd3, 16'd4});
        op(OP_ADD);
        chk("add_busy", 36'(busy), 36'd1);
        chk("add_start", 36'(alu_start), 36'd1);
        chk("add_depth", 36'(depth), 36'd0);
        chk("add_tok_ready", 36'(tok_ready), 36'd0);
        tick();
        chk("add_start_drop", 36'(alu_start), 36'd0);
        chk("add_opnds", {alu_op, alu_a, alu_b}, {OP_ADD, 16'd3, 16'd4});
        alu_done   = 1'b1;
        alu_result = 16'd7;
        tick();
        alu_done = 1'b0;
        chk("add_res_depth", 36'(depth), 36'd1);
        chk("add_res_busy", 36'(busy), 36'd0);

        // POP with the formatter stalling for three cycles
        exp_prt.push_back(16'd7);
        op(OP_POP);
        chk("pop_depth", 36'(depth), 36'd0);
        for (int i = 0; i < 3; i++) begin
            chk("pop_valid_hold", 36'(print_valid), 36'd1);
            chk("pop_data_hold", 36'(print_data), 36'd7);
            tick();
        end
        print_ready = 1'b1;
        chk("pop_valid_last", 36'(print_valid), 36'd1);
        tick();
        print_ready = 1'b0;
        chk("pop_valid_drop", 36'(print_valid), 36'd0);
        chk("pop_idle", 36'(busy), 36'd0);

        // Underflow cases
        exp_err.push_back(ERR_UNDER);
        op(OP_ADD);
        err_pulse(ERR_UNDER, 4'd0);
        push(16'd9);
        exp_err.push_back(ERR_UNDER);
        op(OP_SUB);
        err_pulse(ERR_UNDER, 4'd1);
        exp_err.push_back(ERR_UNDER);
        pop_now(16'd9);
        exp_err.pop_back();
        chk("drain_depth", 36'(depth), 36'd0);
        exp_err.push_back(ERR_UNDER);
        op(OP_POP);
        err_pulse(ERR_UNDER, 4'd0);

        // Fill, overflow, unknown operators
        for (int i = 0; i < DEPTH; i++) push(16'd10 + 16'(i));
        chk("full_depth", 36'(depth), 36'd8);
        chk("full_ready", 36'(tok_ready), 36'd1);
        exp_err.push_back(ERR_OVER);
        push(16'd99);
        err_pulse(ERR_OVER, 4'd8);
        chk("err_hold", 36'(err_code), 36'(ERR_OVER));
        exp_err.push_back(ERR_UNK);
        op(OP_UNKNOWN);
        err_pulse(ERR_UNK, 4'd8);
        exp_err.push_back(ERR_UNK);
        op(4'd5);
        err_pulse(ERR_UNK, 4'd8);
        for (int i = DEPTH - 1; i >= 0; i--) pop_now(16'd10 + 16'(i));
        chk("empty_depth", 36'(depth), 36'd0);

        // Divide by zero reported in the first EXEC cycle
        push(16'd5);
        push(16'd0);
        exp_alu.push_back({OP_DIV, 16'd5, 16'd0});
        op(OP_DIV);
        alu_done = 1'b1;
        alu_err  = 1'b1;
        exp_err.push_back(ERR_DIV0);
        tick();
        alu_done = 1'b0;
        alu_err  = 1'b0;
        err_pulse(ERR_DIV0, 4'd0);

        // Reset in the middle of an ALU operation
        push(16'd1);
        push(16'd2);
        exp_alu.push_back({OP_MUL, 16'd1, 16'd2});
        op(OP_MUL);
        tick();
        rst = 1'b1;
        #1;
        chk("arst_depth", 36'(depth), 36'd0);
        chk("arst_busy", 36'(busy), 36'd0);
        chk("arst_ready", 36'(tok_ready), 36'd1);
        chk("arst_outs", {alu_op, alu_a, 11'd0, alu_start, print_valid,
                          err_valid, err_code}, 36'd0);
        tick();
        rst = 1'b0;
        push(16'd42);
        chk("post_rst_push", 36'(depth), 36'd1);
        pop_now(16'd42);
        tick();

        chk("alu_q_empty", 36'(exp_alu.size()), 36'd0);
        chk("prt_q_empty", 36'(exp_prt.size()), 36'd0);
        chk("err_q_empty", 36'(exp_err.size()), 36'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
